// File: rtl/poly_basemul_seq.sv
// Kyber NTT-domain pointwise product sequencer: streams 128 pairs through basemul_unit into C RAM.
// Optional accumulate mode (C += A*B) enabled by defining BASEMUL_ACC_EN.
module basemul_unit (
    input  logic [11:0] a0,
    input  logic [11:0] a1,
    input  logic [11:0] b0,
    input  logic [11:0] b1,
    input  logic [11:0] gamma,
    output logic [11:0] c0,
    output logic [11:0] c1
);
    localparam logic [25:0] Q = 26'd3329;

    logic [25:0] w_a0b0, w_a1b1, w_a1b1_red, w_a1b1g, w_c0_sum, w_cross;

    always_comb begin
        w_a0b0     = {14'd0, a0} * {14'd0, b0};
        w_a1b1     = {14'd0, a1} * {14'd0, b1};
        // Reduce a1*b1 first so the gamma product stays below 2^24
        w_a1b1_red = w_a1b1 % Q;
        w_a1b1g    = w_a1b1_red * {14'd0, gamma};
        w_c0_sum   = w_a0b0 + w_a1b1g;
        w_cross    = ({14'd0, a0} * {14'd0, b1}) + ({14'd0, a1} * {14'd0, b0});
        c0         = 12'(w_c0_sum % Q);
        c1         = 12'(w_cross % Q);
    end
endmodule

module poly_basemul_seq #(
    parameter int N_PAIRS = 128,
    parameter int AW      = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef BASEMUL_ACC_EN
    input  logic          acc,
    input  logic [23:0]   c_rdata,
`endif
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [23:0]   a_rdata,
    input  logic [23:0]   b_rdata,
    input  logic [11:0]   zeta_rdata,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [23:0]   wr_data
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_PAIRS - 1);

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_idx, w_idx_next;
    logic          w_accept, w_done;
    logic          r_last_wr;

    // Pipeline: r_mem_* aligns with RAM output, r_s1_* holds operands, r_s2_* drives the write port
    logic          r_mem_valid, r_s1_valid, r_s2_valid;
    logic [AW-1:0] r_mem_idx, r_s1_idx, r_s2_idx;
    logic [23:0]   r_s1_a, r_s1_b;
    logic [11:0]   r_s1_zeta;
    logic [11:0]   w_c0, w_c1;
    logic [23:0]   w_result, r_s2_data;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_idx_next   = '0;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                w_idx_next = r_idx + 1'b1;
                if (r_idx == LAST_IDX) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The done cycle also samples start, allowing back-to-back products
                if (r_last_wr) begin
                    w_done = 1'b1;
                    if (start) begin
                        w_state_next = ST_RUN;
                        w_idx_next   = '0;
                        w_accept     = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_last_wr <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_last_wr <= r_s2_valid && (r_s2_idx == LAST_IDX);
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = w_done;
    assign rd_en   = (r_state == ST_RUN);
    assign rd_addr = r_idx;

    basemul_unit u_basemul (
        .a0    (r_s1_a[11:0]),
        .a1    (r_s1_a[23:12]),
        .b0    (r_s1_b[11:0]),
        .b1    (r_s1_b[23:12]),
        .gamma (r_s1_zeta),
        .c0    (w_c0),
        .c1    (w_c1)
    );

`ifdef BASEMUL_ACC_EN
    logic        r_acc;
    logic [23:0] r_s1_c;
    logic [12:0] w_sum0, w_sum1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 1'b0;
            r_s1_c <= '0;
        end else begin
            if (w_accept) r_acc <= acc;
            r_s1_c <= c_rdata;
        end
    end

    always_comb begin
        w_sum0   = {1'b0, w_c0} + {1'b0, r_s1_c[11:0]};
        w_sum1   = {1'b0, w_c1} + {1'b0, r_s1_c[23:12]};
        w_result = {w_c1, w_c0};
        if (r_acc) begin
            w_result[11:0]  = (w_sum0 >= 13'd3329) ? 12'(w_sum0 - 13'd3329) : w_sum0[11:0];
            w_result[23:12] = (w_sum1 >= 13'd3329) ? 12'(w_sum1 - 13'd3329) : w_sum1[11:0];
        end
    end
`else
    assign w_result = {w_c1, w_c0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_idx   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_zeta   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_idx    <= '0;
            r_s2_data   <= '0;
        end else begin
            r_mem_valid <= rd_en;
            r_mem_idx   <= rd_addr;
            r_s1_valid  <= r_mem_valid;
            r_s1_idx    <= r_mem_idx;
            r_s1_a      <= a_rdata;
            r_s1_b      <= b_rdata;
            r_s1_zeta   <= zeta_rdata;
            r_s2_valid  <= r_s1_valid;
            r_s2_idx    <= r_s1_idx;
            r_s2_data   <= w_result;
        end
    end

    assign wr_en   = r_s2_valid;
    assign wr_addr = r_s2_idx;
    assign wr_data = r_s2_data;
endmodule

// File: tb/tb_poly_basemul_seq.sv
// Directed bench for poly_basemul_seq: models the A/B/zeta/C RAMs with 1-cycle read latency.
module tb_poly_basemul_seq;
    localparam int N  = 128;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [23:0]   a_rdata, b_rdata, wr_data;
    logic [11:0]   zeta_rdata;
    logic [23:0]   a_mem [N];
    logic [23:0]   b_mem [N];
    logic [11:0]   z_mem [N];
`ifdef BASEMUL_ACC_EN
    logic          acc;
    logic [23:0]   c_rdata;
    logic [23:0]   c_mem [N];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    poly_basemul_seq #(.N_PAIRS(N), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef BASEMUL_ACC_EN
        .acc        (acc),
        .c_rdata    (c_rdata),
`endif
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .zeta_rdata (zeta_rdata),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata    <= a_mem[rd_addr];
            b_rdata    <= b_mem[rd_addr];
            zeta_rdata <= z_mem[rd_addr];
`ifdef BASEMUL_ACC_EN
            c_rdata    <= c_mem[rd_addr];
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Hand-computed {c1,c0} per pattern
    function automatic logic [23:0] exp_c(input int pat, input int i);
        case (pat)
            0:       return {12'(2 * i), 12'(i)};
            1:       return {12'd0, 12'd17};
            2:       return {12'd2, 12'd0};
            3:       return {12'd12, 12'd171};
            default: return {12'd7, 12'd500};
        endcase
    endfunction

    task automatic load(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: begin a_mem[i] = {12'd0, 12'd1}; b_mem[i] = {12'(2 * i), 12'(i)}; z_mem[i] = 12'd17; end
                1: begin a_mem[i] = {12'd1, 12'd0}; b_mem[i] = {12'd1, 12'd0}; z_mem[i] = 12'd17; end
                2: begin a_mem[i] = {12'd3328, 12'd3328}; b_mem[i] = {12'd3328, 12'd3328}; z_mem[i] = 12'd3328; end
                default: begin a_mem[i] = {12'd0, 12'd1}; b_mem[i] = {12'd7, 12'd500}; z_mem[i] = 12'd17; end
            endcase
`ifdef BASEMUL_ACC_EN
            c_mem[i] = {12'd5, 12'd3000};
`endif
        end
    endtask

    // Runs one product, checking every cycle from k=0 to k=139
    task automatic run_op(input int pat, input bit acc_v, input bit poke_start);
        int writes = 0;
        int dones  = 0;
        load(pat);
        @(posedge clk); #1;
        start = 1'b1;
`ifdef BASEMUL_ACC_EN
        acc = acc_v;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 140; k++) begin
            check("busy", 32'(busy), 32'(k <= N + 3));
            check("rd_en", 32'(rd_en), 32'(k < N));
            if (k < N) check("rd_addr", 32'(rd_addr), 32'(k));
            check("wr_en", 32'(wr_en), 32'(k >= 3 && k <= N + 2));
            if (wr_en) begin
                check("wr_addr", 32'(wr_addr), 32'(writes));
                check("wr_data", 32'(wr_data), 32'(exp_c(pat, int'(wr_addr))));
                writes++;
            end
            check("done", 32'(done), 32'(k == N + 3));
            if (done) dones++;
            start = poke_start && (k == 50);
            @(posedge clk); #1;
        end
        check("write_count", 32'(writes), 32'(N));
        check("done_count", 32'(dones), 32'd1);
        $display("product pat=%0d acc=%0d poke=%0d writes=%0d dones=%0d", pat, acc_v, poke_start, writes, dones);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
`ifdef BASEMUL_ACC_EN
        acc = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;

        run_op(0, 1'b0, 1'b0);
        run_op(1, 1'b0, 1'b0);
        run_op(2, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a product
        load(0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("hold_rst_wr_en", 32'(wr_en), 32'd0);
        rst_n = 1'b1;
        $display("mid-product reset applied at k=40");
        run_op(0, 1'b0, 1'b0);

`ifdef BASEMUL_ACC_EN
        run_op(3, 1'b1, 1'b0);
        run_op(4, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
